// File: rtl/CPU_Defines.sv
// Shared MIPS pipeline definitions: exception flag bundle, Cause codes,
// memory access size encoding and the MEM-stage exception FSM states.
package CPU_Defines;

  typedef struct packed {
    logic IF_AdEL;
    logic RI;
    logic Ov;
    logic Trap;
    logic Syscall;
    logic Break;
    logic Eret;
  } ExcFlags_t;

  localparam logic [4:0] EXC_CODE_INT  = 5'h00;
  localparam logic [4:0] EXC_CODE_ADEL = 5'h04;
  localparam logic [4:0] EXC_CODE_ADES = 5'h05;
  localparam logic [4:0] EXC_CODE_SYS  = 5'h08;
  localparam logic [4:0] EXC_CODE_BP   = 5'h09;
  localparam logic [4:0] EXC_CODE_RI   = 5'h0A;
  localparam logic [4:0] EXC_CODE_OV   = 5'h0C;
  localparam logic [4:0] EXC_CODE_TR   = 5'h0D;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } MemSize_t;

  typedef enum logic {
    EXC_IDLE     = 1'b0,
    EXC_REDIRECT = 1'b1
  } ExcState_t;

  // Byte accesses never fault; the unused size encoding is treated as aligned.
  function automatic logic addr_misaligned(input logic [1:0] addr_lo, input MemSize_t size);
    logic mis;
    mis = 1'b0;
    case (size)
      MEM_SIZE_HALF: mis = addr_lo[0];
      MEM_SIZE_WORD: mis = |addr_lo;
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/exc_priority.sv
// Combinational exception priority encoder for the MEM stage: picks the
// highest-priority cause and the matching Cause code / BadVAddr.
module exc_priority
  import CPU_Defines::*;
(
  input  logic        i_int,
  input  ExcFlags_t   i_flags,
  input  logic        i_adel_d,
  input  logic        i_ades_d,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_data_addr,
  output logic        o_any,
  output logic [4:0]  o_code,
  output logic [31:0] o_badvaddr,
  output logic        o_badvaddr_we,
  output logic        o_eret
);

  always_comb begin
    o_any         = 1'b1;
    o_code        = EXC_CODE_INT;
    o_badvaddr    = '0;
    o_badvaddr_we = 1'b0;
    o_eret        = 1'b0;
    if (i_int) begin
      o_code = EXC_CODE_INT;
    end else if (i_flags.IF_AdEL) begin
      o_code        = EXC_CODE_ADEL;
      o_badvaddr    = i_pc;
      o_badvaddr_we = 1'b1;
    end else if (i_flags.RI) begin
      o_code = EXC_CODE_RI;
    end else if (i_flags.Ov) begin
      o_code = EXC_CODE_OV;
    end else if (i_flags.Trap) begin
      o_code = EXC_CODE_TR;
    end else if (i_flags.Syscall) begin
      o_code = EXC_CODE_SYS;
    end else if (i_flags.Break) begin
      o_code = EXC_CODE_BP;
    end else if (i_adel_d) begin
      o_code        = EXC_CODE_ADEL;
      o_badvaddr    = i_data_addr;
      o_badvaddr_we = 1'b1;
    end else if (i_ades_d) begin
      o_code        = EXC_CODE_ADES;
      o_badvaddr    = i_data_addr;
      o_badvaddr_we = 1'b1;
    end else begin
      // ERET only takes effect when nothing else is pending.
      o_any  = 1'b0;
      o_eret = i_flags.Eret;
    end
  end

endmodule

// File: rtl/mem_exception.sv
// MEM-stage exception collector: latches EXE flags plus data alignment faults,
// commits the winning exception/ERET to CP0 and holds a redirect until fetch accepts.
module mem_exception
  import CPU_Defines::*;
#(
  parameter logic [31:0] RESET_VEC_BEV  = 32'hBFC0_0380,
  parameter logic [31:0] RESET_VEC_NORM = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        EXE_Valid,
  input  logic        EXE_Stall,
  input  logic [31:0] EXE_PC,
  input  logic        EXE_InDelaySlot,
  input  ExcFlags_t   EXE_ExcFlags,
  input  logic [31:0] EXE_DataAddr,
  input  logic        EXE_MemRead,
  input  logic        EXE_MemWrite,
  input  logic [1:0]  EXE_MemSize,
  input  logic        CP0_BEV,
  input  logic        CP0_EXL,
  input  logic [31:0] CP0_EPC,
  input  logic        CP0_IntPending,
  input  logic        Redirect_ready,
  output logic        MEM_Valid,
  output logic [31:0] MEM_PC,
  output logic        Exc_Valid,
  output logic [4:0]  Exc_Code,
  output logic        Exc_BD,
  output logic [31:0] Exc_EPC,
  output logic        Exc_EPCWe,
  output logic [31:0] Exc_BadVAddr,
  output logic        Exc_BadVAddrWe,
  output logic        Eret_Valid,
  output logic        Flush,
  output logic        Redirect_valid,
  output logic [31:0] Redirect_PC
);

  ExcState_t   r_state;
  ExcState_t   w_state_next;
  logic [31:0] r_target;
  logic [31:0] w_target_next;

  logic        r_mem_valid;
  logic [31:0] r_mem_pc;
  logic        r_mem_bd;
  ExcFlags_t   r_mem_flags;
  logic [31:0] r_mem_addr;
  logic        r_mem_adel;
  logic        r_mem_ades;

  logic        w_exe_mis;
  logic        w_any;
  logic [4:0]  w_code;
  logic [31:0] w_badvaddr;
  logic        w_badvaddr_we;
  logic        w_eret_raw;
  logic        w_commit_en;
  logic        w_exc_commit;
  logic        w_eret_commit;
  logic [31:0] w_vector;

  assign w_exe_mis = addr_misaligned(EXE_DataAddr[1:0], MemSize_t'(EXE_MemSize));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_valid <= 1'b0;
      r_mem_pc    <= '0;
      r_mem_bd    <= 1'b0;
      r_mem_flags <= '0;
      r_mem_addr  <= '0;
      r_mem_adel  <= 1'b0;
      r_mem_ades  <= 1'b0;
    end else if (Flush) begin
      // Flush wins over stall so a committed instruction can never commit twice.
      r_mem_valid <= 1'b0;
      r_mem_pc    <= '0;
      r_mem_bd    <= 1'b0;
      r_mem_flags <= '0;
      r_mem_addr  <= '0;
      r_mem_adel  <= 1'b0;
      r_mem_ades  <= 1'b0;
    end else if (!EXE_Stall) begin
      r_mem_valid <= EXE_Valid;
      r_mem_pc    <= EXE_PC;
      r_mem_bd    <= EXE_InDelaySlot;
      r_mem_flags <= EXE_ExcFlags;
      r_mem_addr  <= EXE_DataAddr;
      r_mem_adel  <= EXE_MemRead & w_exe_mis;
      r_mem_ades  <= EXE_MemWrite & w_exe_mis;
    end
  end

  exc_priority u_exc_priority (
    .i_int         (CP0_IntPending),
    .i_flags       (r_mem_flags),
    .i_adel_d      (r_mem_adel),
    .i_ades_d      (r_mem_ades),
    .i_pc          (r_mem_pc),
    .i_data_addr   (r_mem_addr),
    .o_any         (w_any),
    .o_code        (w_code),
    .o_badvaddr    (w_badvaddr),
    .o_badvaddr_we (w_badvaddr_we),
    .o_eret        (w_eret_raw)
  );

  assign w_commit_en   = (r_state == EXC_IDLE) & r_mem_valid;
  assign w_exc_commit  = w_commit_en & w_any;
  assign w_eret_commit = w_commit_en & w_eret_raw;
  assign w_vector      = CP0_BEV ? RESET_VEC_BEV : RESET_VEC_NORM;

  assign MEM_Valid      = r_mem_valid;
  assign MEM_PC         = r_mem_pc;
  assign Exc_Valid      = w_exc_commit;
  assign Exc_Code       = w_exc_commit ? w_code : '0;
  assign Exc_BD         = w_exc_commit & r_mem_bd;
  assign Exc_EPC        = w_exc_commit ? (r_mem_bd ? r_mem_pc - 32'd4 : r_mem_pc) : '0;
  assign Exc_EPCWe      = w_exc_commit & ~CP0_EXL;
  assign Exc_BadVAddr   = w_exc_commit ? w_badvaddr : '0;
  assign Exc_BadVAddrWe = w_exc_commit & w_badvaddr_we;
  assign Eret_Valid     = w_eret_commit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= EXC_IDLE;
      r_target <= '0;
    end else begin
      r_state  <= w_state_next;
      r_target <= w_target_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_target_next  = r_target;
    Flush          = 1'b0;
    Redirect_valid = 1'b0;
    Redirect_PC    = '0;
    case (r_state)
      EXC_IDLE: begin
        if (w_exc_commit) begin
          w_state_next  = EXC_REDIRECT;
          w_target_next = w_vector;
          Flush         = 1'b1;
        end else if (w_eret_commit) begin
          w_state_next  = EXC_REDIRECT;
          w_target_next = CP0_EPC;
          Flush         = 1'b1;
        end
      end
      EXC_REDIRECT: begin
        // Target was captured at commit, so later CP0 changes cannot move it.
        Redirect_valid = 1'b1;
        Redirect_PC    = r_target;
        Flush          = 1'b1;
        if (Redirect_ready) w_state_next = EXC_IDLE;
      end
      default: w_state_next = EXC_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_exception.sv
// Self-checking bench for mem_exception: an instruction-level model predicts
// every output each cycle, and directed cases pin hand-computed values.
module tb_mem_exception;

  localparam logic [6:0] F_IFADEL = 7'b1000000;
  localparam logic [6:0] F_RI     = 7'b0100000;
  localparam logic [6:0] F_OV     = 7'b0010000;
  localparam logic [6:0] F_TRAP   = 7'b0001000;
  localparam logic [6:0] F_SYS    = 7'b0000100;
  localparam logic [6:0] F_BRK    = 7'b0000010;
  localparam logic [6:0] F_ERET   = 7'b0000001;

  logic        clk = 1'b0;
  logic        resetn;
  logic        EXE_Valid, EXE_Stall;
  logic [31:0] EXE_PC;
  logic        EXE_InDelaySlot;
  logic [6:0]  EXE_ExcFlags;
  logic [31:0] EXE_DataAddr;
  logic        EXE_MemRead, EXE_MemWrite;
  logic [1:0]  EXE_MemSize;
  logic        CP0_BEV, CP0_EXL;
  logic [31:0] CP0_EPC;
  logic        CP0_IntPending, Redirect_ready;
  logic        MEM_Valid;
  logic [31:0] MEM_PC;
  logic        Exc_Valid;
  logic [4:0]  Exc_Code;
  logic        Exc_BD;
  logic [31:0] Exc_EPC;
  logic        Exc_EPCWe;
  logic [31:0] Exc_BadVAddr;
  logic        Exc_BadVAddrWe;
  logic        Eret_Valid, Flush, Redirect_valid;
  logic [31:0] Redirect_PC;

  int n_checks = 0;
  int n_errors = 0;

  mem_exception dut (
    .clk(clk), .resetn(resetn),
    .EXE_Valid(EXE_Valid), .EXE_Stall(EXE_Stall), .EXE_PC(EXE_PC),
    .EXE_InDelaySlot(EXE_InDelaySlot), .EXE_ExcFlags(EXE_ExcFlags),
    .EXE_DataAddr(EXE_DataAddr), .EXE_MemRead(EXE_MemRead),
    .EXE_MemWrite(EXE_MemWrite), .EXE_MemSize(EXE_MemSize),
    .CP0_BEV(CP0_BEV), .CP0_EXL(CP0_EXL), .CP0_EPC(CP0_EPC),
    .CP0_IntPending(CP0_IntPending), .Redirect_ready(Redirect_ready),
    .MEM_Valid(MEM_Valid), .MEM_PC(MEM_PC),
    .Exc_Valid(Exc_Valid), .Exc_Code(Exc_Code), .Exc_BD(Exc_BD),
    .Exc_EPC(Exc_EPC), .Exc_EPCWe(Exc_EPCWe),
    .Exc_BadVAddr(Exc_BadVAddr), .Exc_BadVAddrWe(Exc_BadVAddrWe),
    .Eret_Valid(Eret_Valid), .Flush(Flush),
    .Redirect_valid(Redirect_valid), .Redirect_PC(Redirect_PC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic [6:0]  flags;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
  } mem_t;

  typedef struct packed {
    logic        exc_valid;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] epc;
    logic        epc_we;
    logic [31:0] bva;
    logic        bva_we;
    logic        eret_valid;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
  } exp_t;

  mem_t        m_mem;
  logic        m_redir;
  logic [31:0] m_target;
  exp_t        exp_now;

  function automatic exp_t model_expect(input mem_t m, input logic redir, input logic [31:0] target,
                                        input logic intp, input logic exl);
    exp_t e;
    int   bytes;
    bit   mis;
    bit   [8:0] cause;
    bit   [4:0] codes [9] = '{5'h05, 5'h04, 5'h09, 5'h08, 5'h0D, 5'h0C, 5'h0A, 5'h04, 5'h00};
    e = '0;
    bytes = 1 << m.size;
    mis = (m.size == 2'd1 || m.size == 2'd2) && ((m.addr % bytes) != 0);
    // Highest priority in bit 8: Int, IF_AdEL, RI, Ov, Trap, Sys, Bp, AdEL_D, AdES_D.
    cause = {intp, m.flags[6:1], mis && m.rd, mis && m.wr};
    if (!redir && m.valid) begin
      for (int k = 8; k >= 0; k--) begin
        if (cause[k] && !e.exc_valid) begin
          e.exc_valid = 1'b1;
          e.code = codes[k];
          if (k == 7) begin e.bva = m.pc;   e.bva_we = 1'b1; end
          if (k <= 1) begin e.bva = m.addr; e.bva_we = 1'b1; end
        end
      end
      if (e.exc_valid) begin
        e.bd = m.bd;
        e.epc = m.bd ? m.pc - 32'd4 : m.pc;
        e.epc_we = !exl;
      end else if (m.flags[0]) begin
        e.eret_valid = 1'b1;
      end
    end
    e.flush = e.exc_valid || e.eret_valid || redir;
    e.rv = redir;
    e.rpc = redir ? target : 32'h0;
    return e;
  endfunction

  always_comb exp_now = model_expect(m_mem, m_redir, m_target, CP0_IntPending, CP0_EXL);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_mem    <= '0;
      m_redir  <= 1'b0;
      m_target <= 32'h0;
    end else begin
      if (exp_now.flush) m_mem <= '0;
      else if (!EXE_Stall)
        m_mem <= {EXE_Valid, EXE_PC, EXE_InDelaySlot, EXE_ExcFlags, EXE_DataAddr,
                  EXE_MemRead, EXE_MemWrite, EXE_MemSize};
      if (!m_redir) begin
        if (exp_now.exc_valid) begin
          m_redir  <= 1'b1;
          m_target <= CP0_BEV ? 32'hBFC0_0380 : 32'h8000_0180;
        end else if (exp_now.eret_valid) begin
          m_redir  <= 1'b1;
          m_target <= CP0_EPC;
        end
      end else if (Redirect_ready) begin
        m_redir <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp.Exc_Valid",      {31'b0, Exc_Valid},      {31'b0, exp_now.exc_valid});
    chk("cmp.Exc_Code",       {27'b0, Exc_Code},       {27'b0, exp_now.code});
    chk("cmp.Exc_BD",         {31'b0, Exc_BD},         {31'b0, exp_now.bd});
    chk("cmp.Exc_EPC",        Exc_EPC,                 exp_now.epc);
    chk("cmp.Exc_EPCWe",      {31'b0, Exc_EPCWe},      {31'b0, exp_now.epc_we});
    chk("cmp.Exc_BadVAddr",   Exc_BadVAddr,            exp_now.bva);
    chk("cmp.Exc_BadVAddrWe", {31'b0, Exc_BadVAddrWe}, {31'b0, exp_now.bva_we});
    chk("cmp.Eret_Valid",     {31'b0, Eret_Valid},     {31'b0, exp_now.eret_valid});
    chk("cmp.Flush",          {31'b0, Flush},          {31'b0, exp_now.flush});
    chk("cmp.Redirect_valid", {31'b0, Redirect_valid}, {31'b0, exp_now.rv});
    chk("cmp.Redirect_PC",    Redirect_PC,             exp_now.rpc);
    chk("cmp.MEM_Valid",      {31'b0, MEM_Valid},      {31'b0, m_mem.valid});
    chk("cmp.MEM_PC",         MEM_PC,                  m_mem.pc);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_exe();
    EXE_Valid = 1'b0; EXE_PC = 32'h0; EXE_InDelaySlot = 1'b0; EXE_ExcFlags = 7'b0;
    EXE_DataAddr = 32'h0; EXE_MemRead = 1'b0; EXE_MemWrite = 1'b0; EXE_MemSize = 2'd0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic bd, input logic [6:0] flags,
                       input logic [31:0] addr, input logic rd, input logic wr, input logic [1:0] size);
    $display("issue pc=%h bd=%0d flags=%b addr=%h rd=%0d wr=%0d size=%0d", pc, bd, flags, addr, rd, wr, size);
    EXE_Valid = 1'b1; EXE_PC = pc; EXE_InDelaySlot = bd; EXE_ExcFlags = flags;
    EXE_DataAddr = addr; EXE_MemRead = rd; EXE_MemWrite = wr; EXE_MemSize = size;
    cyc();
    idle_exe();
  endtask

  task automatic expect_exc(input string tag, input logic [4:0] code, input logic [31:0] epc,
                            input logic bd, input logic epcwe, input logic [31:0] bva,
                            input logic bvawe, input logic [31:0] rpc);
    @(negedge clk);
    chk({tag, ".Exc_Valid"},      {31'b0, Exc_Valid},      32'd1);
    chk({tag, ".Exc_Code"},       {27'b0, Exc_Code},       {27'b0, code});
    chk({tag, ".Exc_EPC"},        Exc_EPC,                 epc);
    chk({tag, ".Exc_BD"},         {31'b0, Exc_BD},         {31'b0, bd});
    chk({tag, ".Exc_EPCWe"},      {31'b0, Exc_EPCWe},      {31'b0, epcwe});
    chk({tag, ".Exc_BadVAddr"},   Exc_BadVAddr,            bva);
    chk({tag, ".Exc_BadVAddrWe"}, {31'b0, Exc_BadVAddrWe}, {31'b0, bvawe});
    chk({tag, ".Eret_Valid"},     {31'b0, Eret_Valid},     32'd0);
    chk({tag, ".Flush"},          {31'b0, Flush},          32'd1);
    cyc();
    @(negedge clk);
    chk({tag, ".Redirect_valid"}, {31'b0, Redirect_valid}, 32'd1);
    chk({tag, ".Redirect_PC"},    Redirect_PC,             rpc);
    Redirect_ready = 1'b1;
    cyc();
    Redirect_ready = 1'b0;
  endtask

  task automatic expect_none(input string tag);
    @(negedge clk);
    chk({tag, ".Exc_Valid"},  {31'b0, Exc_Valid},  32'd0);
    chk({tag, ".Eret_Valid"}, {31'b0, Eret_Valid}, 32'd0);
    chk({tag, ".Flush"},      {31'b0, Flush},      32'd0);
    cyc();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 1'b0; EXE_Stall = 1'b0; CP0_BEV = 1'b0; CP0_EXL = 1'b0;
    CP0_EPC = 32'h0; CP0_IntPending = 1'b0; Redirect_ready = 1'b0;
    idle_exe();
    repeat (3) cyc();
    chk("reset.MEM_Valid",      {31'b0, MEM_Valid},      32'd0);
    chk("reset.MEM_PC",         MEM_PC,                  32'd0);
    chk("reset.Redirect_valid", {31'b0, Redirect_valid}, 32'd0);
    chk("reset.Flush",          {31'b0, Flush},          32'd0);
    resetn = 1'b1;
    cyc();

    issue(32'h8000_1004, 1'b1, F_TRAP, 32'h0, 1'b0, 1'b0, 2'd0);
    expect_exc("trap_ds", 5'h0D, 32'h8000_1000, 1'b1, 1'b1, 32'h0, 1'b0, 32'h8000_0180);

    issue(32'h8000_0100, 1'b0, F_RI | F_OV | F_TRAP, 32'h0, 1'b0, 1'b0, 2'd0);
    expect_exc("ri_ov_tr", 5'h0A, 32'h8000_0100, 1'b0, 1'b1, 32'h0, 1'b0, 32'h8000_0180);

    CP0_IntPending = 1'b1;
    expect_none("int_bubble");
    issue(32'hBFC0_0002, 1'b0, F_IFADEL, 32'h0, 1'b0, 1'b0, 2'd0);
    expect_exc("int_ifadel", 5'h00, 32'hBFC0_0002, 1'b0, 1'b1, 32'h0, 1'b0, 32'h8000_0180);
    CP0_IntPending = 1'b0;

    issue(32'h8000_0003, 1'b0, F_IFADEL, 32'h0, 1'b0, 1'b0, 2'd0);
    expect_exc("ifadel", 5'h04, 32'h8000_0003, 1'b0, 1'b1, 32'h8000_0003, 1'b1, 32'h8000_0180);

    issue(32'h8000_0200, 1'b0, 7'b0, 32'h1000_0006, 1'b0, 1'b1, 2'd2);
    expect_exc("sw_mis", 5'h05, 32'h8000_0200, 1'b0, 1'b1, 32'h1000_0006, 1'b1, 32'h8000_0180);

    issue(32'h8000_0204, 1'b0, 7'b0, 32'h1000_0006, 1'b1, 1'b0, 2'd1);
    expect_none("lh_ok");

    issue(32'h8000_0300, 1'b0, 7'b0, 32'h1000_0001, 1'b1, 1'b0, 2'd1);
    expect_exc("lh_mis", 5'h04, 32'h8000_0300, 1'b0, 1'b1, 32'h1000_0001, 1'b1, 32'h8000_0180);

    for (int a = 0; a < 4; a++) begin
      issue(32'h8000_0310 + a, 1'b0, 7'b0, 32'h1000_0000 + a, a[0], ~a[0], 2'd0);
      expect_none("byte");
    end
    issue(32'h8000_0320, 1'b0, 7'b0, 32'h1000_0004, 1'b1, 1'b0, 2'd2);
    expect_none("lw_ok");

    issue(32'h8000_0600, 1'b0, F_BRK, 32'h0, 1'b0, 1'b0, 2'd0);
    expect_exc("break", 5'h09, 32'h8000_0600, 1'b0, 1'b1, 32'h0, 1'b0, 32'h8000_0180);

    issue(32'h8000_0500, 1'b0, F_ERET | F_SYS, 32'h0, 1'b0, 1'b0, 2'd0);
    expect_exc("eret_sys", 5'h08, 32'h8000_0500, 1'b0, 1'b1, 32'h0, 1'b0, 32'h8000_0180);

    // ERET with a held redirect; a Trap arriving meanwhile must be bubbled.
    CP0_EPC = 32'h8000_2000;
    issue(32'h8000_0700, 1'b0, F_ERET, 32'h0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    chk("eret.Eret_Valid", {31'b0, Eret_Valid}, 32'd1);
    chk("eret.Exc_Valid",  {31'b0, Exc_Valid},  32'd0);
    chk("eret.Flush",      {31'b0, Flush},      32'd1);
    cyc();
    CP0_EPC = 32'hDEAD_0000;
    CP0_BEV = 1'b1;
    EXE_Valid = 1'b1; EXE_PC = 32'h8000_5000; EXE_ExcFlags = F_TRAP;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("eret_hold.Redirect_valid", {31'b0, Redirect_valid}, 32'd1);
      chk("eret_hold.Redirect_PC",    Redirect_PC,             32'h8000_2000);
      chk("eret_hold.Flush",          {31'b0, Flush},          32'd1);
      chk("eret_hold.Exc_Valid",      {31'b0, Exc_Valid},      32'd0);
      cyc();
      idle_exe();
    end
    Redirect_ready = 1'b1;
    cyc();
    Redirect_ready = 1'b0;
    CP0_BEV = 1'b0;
    @(negedge clk);
    chk("eret_after.MEM_Valid", {31'b0, MEM_Valid}, 32'd0);
    expect_none("eret_after");

    CP0_EXL = 1'b1; CP0_BEV = 1'b1;
    issue(32'h8000_0400, 1'b0, F_SYS, 32'h0, 1'b0, 1'b0, 2'd0);
    expect_exc("exl_bev", 5'h08, 32'h8000_0400, 1'b0, 1'b0, 32'h0, 1'b0, 32'hBFC0_0380);
    CP0_EXL = 1'b0; CP0_BEV = 1'b0;

    // Stall holds MEM contents.
    issue(32'h8000_3000, 1'b0, 7'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    EXE_Stall = 1'b1; EXE_Valid = 1'b1; EXE_PC = 32'h8000_3004;
    cyc(); cyc();
    @(negedge clk);
    chk("stall.MEM_PC", MEM_PC, 32'h8000_3000);
    EXE_Stall = 1'b0; idle_exe();
    cyc();

    // Stall during a commit: the flush still bubbles MEM, no second commit.
    issue(32'h8000_4000, 1'b0, F_TRAP, 32'h0, 1'b0, 1'b0, 2'd0);
    EXE_Stall = 1'b1; EXE_Valid = 1'b1; EXE_PC = 32'h8000_4004; EXE_ExcFlags = F_SYS;
    @(negedge clk);
    chk("stall_exc.Exc_Code", {27'b0, Exc_Code}, 32'h0D);
    cyc();
    @(negedge clk);
    chk("stall_exc.MEM_Valid", {31'b0, MEM_Valid}, 32'd0);
    Redirect_ready = 1'b1;
    cyc();
    Redirect_ready = 1'b0;
    expect_none("stall_exc_idle");
    EXE_Stall = 1'b0; idle_exe();
    cyc();

    // Asynchronous reset in the middle of a redirect.
    issue(32'h8000_6000, 1'b0, F_TRAP, 32'h0, 1'b0, 1'b0, 2'd0);
    cyc();
    resetn = 1'b0;
    #1;
    chk("rst_mid.Redirect_valid", {31'b0, Redirect_valid}, 32'd0);
    chk("rst_mid.MEM_Valid",      {31'b0, MEM_Valid},      32'd0);
    chk("rst_mid.Flush",          {31'b0, Flush},          32'd0);
    cyc(); cyc();
    resetn = 1'b1;
    cyc();
    issue(32'h8000_7000, 1'b0, F_SYS, 32'h0, 1'b0, 1'b0, 2'd0);
    expect_exc("post_rst", 5'h08, 32'h8000_7000, 1'b0, 1'b1, 32'h0, 1'b0, 32'h8000_0180);

    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
